// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU-sharing arbiter: FSM encoding and the ALUFun
// codes that the ALU and control unit agree on.
package alu_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_MOV = 6'b011010;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// Two-way round-robin grant. prio_q names the requester that wins a tie; it
// moves to the other requester only when a grant is actually accepted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic prio_q, prio_d;

  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    if (accept) begin
      prio_d = ~gnt[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters. Operands are
// registered into the ALU and the result is registered back out; one op at a time.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int FUN_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_A,
  input  logic [2*WIDTH-1:0]   req_B,
  input  logic [2*FUN_W-1:0]   req_ALUFun,
  input  logic [1:0]           req_Sign,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [WIDTH-1:0]     rsp_S,
  output logic [WIDTH-1:0]     alu_A,
  output logic [WIDTH-1:0]     alu_B,
  output logic [FUN_W-1:0]     alu_ALUFun,
  output logic                 alu_Sign,
  input  logic [WIDTH-1:0]     alu_S
);

  import alu_share_arbiter_pkg::*;

  // Handshake rule, both directions: a transfer happens in a cycle where
  // valid and ready are both high for the same requester bit.
  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [FUN_W-1:0]   fun_q, fun_d;
  logic               sign_q, sign_d;
  logic [1:0]         gnt;
  logic               accept;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .accept (accept),
    .gnt    (gnt)
  );

  assign accept = |req_ready;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    a_d       = a_q;
    b_d       = b_q;
    fun_d     = fun_q;
    sign_d    = sign_q;
    res_d     = res_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    case (state_q)
      IDLE: begin
        if (!reset && (gnt != 2'b00)) begin
          req_ready = gnt;
          owner_d   = gnt[1];
          a_d       = gnt[1] ? req_A[2*WIDTH-1:WIDTH]      : req_A[WIDTH-1:0];
          b_d       = gnt[1] ? req_B[2*WIDTH-1:WIDTH]      : req_B[WIDTH-1:0];
          fun_d     = gnt[1] ? req_ALUFun[2*FUN_W-1:FUN_W] : req_ALUFun[FUN_W-1:0];
          sign_d    = gnt[1] ? req_Sign[1]                 : req_Sign[0];
          state_d   = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_S;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      sign_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
    end
  end

  assign alu_A      = a_q;
  assign alu_B      = b_q;
  assign alu_ALUFun = fun_q;
  assign alu_Sign   = sign_q;
  assign rsp_S      = res_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a vector table of single ops, hand-written
// sequences for arbitration/backpressure/reset, and a result scoreboard.
module tb_alu_share_arbiter;

  import alu_share_arbiter_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_A;
  logic [63:0] req_B;
  logic [11:0] req_ALUFun;
  logic [1:0]  req_Sign;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_S;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [5:0]  alu_ALUFun;
  logic        alu_Sign;
  logic [31:0] alu_S;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] exp_q[$];
  bit          own_q[$];

  alu_share_arbiter #(.WIDTH(32), .FUN_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_A      (req_A),
    .req_B      (req_B),
    .req_ALUFun (req_ALUFun),
    .req_Sign   (req_Sign),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_S      (rsp_S),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_ALUFun (alu_ALUFun),
    .alu_Sign   (alu_Sign),
    .alu_S      (alu_S)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Stand-in for the external ALU.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] fun);
    case (fun)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_NOR: return ~(a | b);
      ALU_MOV: return a;
      default: return 32'h0;
    endcase
  endfunction

  assign alu_S = ref_alu(alu_A, alu_B, alu_ALUFun);

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [1:0] oh(input int idx);
    return (idx == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] fun, input logic sgn);
    req_A[idx*32 +: 32]     = a;
    req_B[idx*32 +: 32]     = b;
    req_ALUFun[idx*6 +: 6]  = fun;
    req_Sign[idx]           = sgn;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic do_single(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] fun, input logic [31:0] exp_s);
    logic sgn;
    sgn = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    set_req(idx, a, b, fun, sgn);
    req_valid = oh(idx);
    rsp_ready = oh(idx);
    @(negedge clk);
    check("req_ready_same_cycle", req_ready, oh(idx));
    @(posedge clk); #1;
    req_valid = 2'b00;
    req_A = {$urandom, $urandom};
    req_B = {$urandom, $urandom};
    @(negedge clk);
    check("exec_alu_A", alu_A, a);
    check("exec_alu_B", alu_B, b);
    check("exec_alu_fun", alu_ALUFun, fun);
    check("exec_alu_sign", alu_Sign, sgn);
    check("exec_no_rsp", rsp_valid, 2'b00);
    @(negedge clk);
    check("resp_valid", rsp_valid, oh(idx));
    check("resp_S", rsp_S, exp_s);
    check("resp_alu_A_held", alu_A, a);
    @(posedge clk); #1;
    rsp_ready = 2'b00;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [1:0]  want_oh;
    logic        gi;
    if (reset) begin
      exp_q.delete();
      own_q.delete();
    end else begin
      if (rsp_valid != 2'b00) begin
        if (own_q.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 2'b00);
        end else begin
          want_oh = own_q[0] ? 2'b10 : 2'b01;
          check("sb_rsp_owner", rsp_valid, want_oh);
          if ((rsp_valid & rsp_ready) != 2'b00) begin
            check("sb_rsp_data", rsp_S, exp_q.pop_front());
            void'(own_q.pop_front());
          end
        end
      end
      if ((req_valid & req_ready) != 2'b00) begin
        gi = req_ready[1];
        own_q.push_back(gi);
        exp_q.push_back(ref_alu(gi ? req_A[63:32] : req_A[31:0],
                                gi ? req_B[63:32] : req_B[31:0],
                                gi ? req_ALUFun[11:6] : req_ALUFun[5:0]));
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fun;
    logic [31:0] exp_s;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int g;
    int want_owner[4];

    vecs[0] = '{0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_AND, 32'h00F0_00F0};
    vecs[1] = '{1, 32'h0000_0001, 32'hFFFF_FFFF, ALU_ADD, 32'h0000_0000};
    vecs[2] = '{0, 32'h0000_0005, 32'h0000_0007, ALU_SUB, 32'hFFFF_FFFE};
    vecs[3] = '{1, 32'h1234_0000, 32'h0000_5678, ALU_OR,  32'h1234_5678};
    vecs[4] = '{0, 32'hFFFF_0000, 32'hFF00_FF00, ALU_XOR, 32'h00FF_FF00};
    vecs[5] = '{1, 32'h0000_0000, 32'h0000_0000, ALU_NOR, 32'hFFFF_FFFF};
    vecs[6] = '{0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, ALU_NOR, 32'h0000_0000};
    vecs[7] = '{1, 32'hDEAD_BEEF, 32'h1357_9BDF, ALU_MOV, 32'hDEAD_BEEF};
    want_owner = '{0, 1, 0, 1};

    reset      = 1'b1;
    req_valid  = 2'b11;
    rsp_ready  = 2'b00;
    req_A      = {32'h1111_1111, 32'h2222_2222};
    req_B      = {32'h3333_3333, 32'h4444_4444};
    req_ALUFun = {ALU_XOR, ALU_OR};
    req_Sign   = 2'b11;

    // Reset state, with both requesters pushing.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_S", rsp_S, 32'h0);
    check("rst_alu_A", alu_A, 32'h0);
    check("rst_alu_B", alu_B, 32'h0);
    check("rst_alu_fun", alu_ALUFun, 6'h0);
    check("rst_alu_sign", alu_Sign, 1'b0);
    @(posedge clk); #1;
    reset     = 1'b0;
    req_valid = 2'b00;

    for (int i = 0; i < 8; i++) begin
      do_single(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].fun, vecs[i].exp_s);
    end

    // Both valid every cycle: grants alternate starting with requester 0.
    do_reset();
    @(posedge clk); #1;
    set_req(0, 32'h1, 32'h2, ALU_OR, 1'b0);
    set_req(1, 32'hFF, 32'h0F, ALU_XOR, 1'b0);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    g = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00 && g < 4) begin
        check("grant_order", req_ready, oh(want_owner[g]));
        g++;
      end
      if (rsp_valid != 2'b00) begin
        check("pair_rsp_S", rsp_S, rsp_valid[0] ? 32'h3 : 32'hF0);
      end
    end
    check("grant_count", g, 4);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rsp_ready = 2'b00;

    // Response backpressure on requester 1 with requester 0 pending.
    set_req(1, 32'h10, 32'h20, ALU_ADD, 1'b0);
    req_valid = 2'b10;
    @(negedge clk);
    check("bp_grant1", req_ready, 2'b10);
    @(posedge clk); #1;
    set_req(0, 32'h7, 32'h8, ALU_ADD, 1'b0);
    req_valid = 2'b01;
    @(negedge clk);
    check("bp_exec_ready", req_ready, 2'b00);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 2'b10);
      check("bp_rsp_S", rsp_S, 32'h30);
      check("bp_req_ready", req_ready, 2'b00);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b10;
    @(negedge clk);
    check("bp_release_valid", rsp_valid, 2'b10);
    check("bp_release_ready", req_ready, 2'b00);
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    @(negedge clk);
    check("bp_pending_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    repeat (3) @(posedge clk);
    #1;

    // Wrong-owner ready must not retire requester 0's response.
    set_req(0, 32'hAAAA_0000, 32'h0000_AAAA, ALU_OR, 1'b0);
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    @(posedge clk); #1;
    set_req(1, 32'h3, 32'h1, ALU_SUB, 1'b1);
    req_valid = 2'b10;
    @(posedge clk); #1;
    rsp_ready = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wo_rsp_valid", rsp_valid, 2'b01);
      check("wo_rsp_S", rsp_S, 32'hAAAA_AAAA);
      check("wo_req_ready", req_ready, 2'b00);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b01;
    @(negedge clk);
    check("wo_final_valid", rsp_valid, 2'b01);
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    @(negedge clk);
    check("wo_next_grant", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1;

    // Reset while an op sits in EXEC.
    set_req(0, 32'h0, 32'h0, ALU_NOR, 1'b1);
    req_valid = 2'b01;
    @(negedge clk);
    check("rx_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    reset     = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    check("rx_exec_fun", alu_ALUFun, ALU_NOR);
    check("rx_ready_in_reset", req_ready, 2'b00);
    @(posedge clk); #1;
    reset     = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    check("rx_alu_A", alu_A, 32'h0);
    check("rx_alu_B", alu_B, 32'h0);
    check("rx_alu_fun", alu_ALUFun, 6'h0);
    check("rx_alu_sign", alu_Sign, 1'b0);
    check("rx_rsp_S", rsp_S, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rx_no_rsp", rsp_valid, 2'b00);
    end
    @(posedge clk); #1;
    set_req(0, 32'h5, 32'h6, ALU_ADD, 1'b0);
    set_req(1, 32'h9, 32'h4, ALU_SUB, 1'b0);
    req_valid = 2'b11;
    @(negedge clk);
    check("rx_pair_grant0", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1;

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
